// File: rtl/demux_logic_unit_if.sv
// Operand/result handshake bundle for demux_logic_unit.
// The source drives the operand side, and the sink drives out_ready.
interface demux_logic_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             parity;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y, zero, parity
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y, zero, parity
  );
endinterface

// File: rtl/demux_logic_unit.sv
// Two-stage bitwise logic unit. Each bit pair is decoded to a one-hot minterm,
// and a registered opcode then selects one of eight functions.
module demux_logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  demux_logic_unit_if.slave bus,
  output logic [CNT_W-1:0]  count
);
  logic [WIDTH-1:0][3:0] m_d, m_q;
  logic [2:0]            op_q;
  logic                  s1_valid_q, out_valid_q;
  logic [WIDTH-1:0]      y_d, y_q;
  logic                  zero_q, parity_q;
  logic [CNT_W-1:0]      count_q;
  logic                  advance, xfer;

  function automatic logic sel_fn(input logic [2:0] op, input logic [3:0] m);
    logic r;
    r = 1'b0;
    unique case (op)
      3'd0: r = m[3];
      3'd1: r = m[1] | m[2] | m[3];
      3'd2: r = m[0] | m[1];
      3'd3: r = ~m[3];
      3'd4: r = m[0];
      3'd5: r = m[1] | m[2];
      3'd6: r = m[0] | m[3];
      3'd7: r = m[2] | m[3];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // A 1:4 demux with its input tied high: sel={a,b} lights exactly one line.
    assign m_d[i] = 4'b0001 << {bus.a[i], bus.b[i]};
    assign y_d[i] = sel_fn(op_q, m_q[i]);
  end

  assign advance      = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = ~s1_valid_q | advance;
  assign xfer         = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      m_q        <= '0;
      op_q       <= '0;
    end else begin
      // An empty stage 1 can fill even while stage 2 is stalled.
      if (xfer) begin
        s1_valid_q <= 1'b1;
        m_q        <= m_d;
        op_q       <= bus.op;
      end else if (advance) begin
        s1_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (advance) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          y_q      <= y_d;
          zero_q   <= ~|y_d;
          parity_q <= ^y_d;
        end
      end
      if (out_valid_q & bus.out_ready) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign bus.zero      = zero_q;
  assign bus.parity    = parity_q;
  assign count         = count_q;
endmodule

// File: tb/tb_demux_logic_unit.sv
// Bench for demux_logic_unit: a vector table, a result scoreboard and
// hand-written flow-control, reset and counter-wrap sequences.
module tb_demux_logic_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] count;
  logic [3:0]  cnt2;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  demux_logic_unit_if #(.WIDTH(8)) bus ();
  demux_logic_unit_if #(.WIDTH(8)) bus2 ();

  demux_logic_unit #(.WIDTH(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus), .count(count));
  demux_logic_unit #(.WIDTH(8), .CNT_W(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2), .count(cnt2));

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       p;
  } sb_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] y;
    logic       z;
    logic       p;
  } vec_t;

  sb_t sbq[$];
  sb_t exp_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic sb_t mk(input logic [7:0] y);
    sb_t e;
    e.y = y;
    e.z = (y == 8'h00);
    e.p = ^y;
    return e;
  endfunction

  // Scoreboard check on every output handshake.
  always @(negedge clk) begin
    if (rst) sbq.delete();
    else if (bus.out_valid && bus.out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected got y=%h want no output", bus.y);
      end else begin
        exp_e = sbq.pop_front();
        chk("sb_y", 32'(bus.y), 32'(exp_e.y));
        chk("sb_zero", 32'(bus.zero), 32'(exp_e.z));
        chk("sb_parity", 32'(bus.parity), 32'(exp_e.p));
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input sb_t e, output int waits);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.op = op;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout got in_ready=0 want 1");
    end else sbq.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 32'(sbq.size()), 32'd0);
  endtask

  vec_t tbl[10];
  int w, waits_sum, nres, cyc;
  logic [7:0] ra, rb, hy;
  logic [2:0] rop;
  logic saw_stall, hs;

  initial begin
    tbl[0] = '{8'hF0, 8'hCC, 3'd0, 8'hC0, 1'b0, 1'b0};
    tbl[1] = '{8'hF0, 8'hCC, 3'd1, 8'hFC, 1'b0, 1'b0};
    tbl[2] = '{8'hF0, 8'hCC, 3'd2, 8'h0F, 1'b0, 1'b0};
    tbl[3] = '{8'hF0, 8'hCC, 3'd3, 8'h3F, 1'b0, 1'b0};
    tbl[4] = '{8'hF0, 8'hCC, 3'd4, 8'h03, 1'b0, 1'b0};
    tbl[5] = '{8'hF0, 8'hCC, 3'd5, 8'h3C, 1'b0, 1'b0};
    tbl[6] = '{8'hF0, 8'hCC, 3'd6, 8'hC3, 1'b0, 1'b0};
    tbl[7] = '{8'hF0, 8'hCC, 3'd7, 8'hF0, 1'b0, 1'b0};
    tbl[8] = '{8'h00, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0};
    tbl[9] = '{8'h07, 8'h00, 3'd7, 8'h07, 1'b0, 1'b1};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.a = 8'h5A; bus2.b = 8'h3C; bus2.op = 3'd5; bus2.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", 32'(bus.y), 32'd0);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    chk("rst_parity", 32'(bus.parity), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: result visible after the second edge.
    send(8'hF0, 8'hCC, 3'd0, mk(8'hC0), w);
    chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_y", 32'(bus.y), 32'hC0);
    drain();

    // Truth table and flags, back to back.
    for (int i = 0; i < 10; i++) send(tbl[i].a, tbl[i].b, tbl[i].op, '{tbl[i].y, tbl[i].z, tbl[i].p}, w);
    drain();

    // Backpressure.
    do_reset();
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
          send(ra, rb, rop, mk(ref_y(ra, rb, rop)), w);
        end
      end
      begin
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        chk("bp_first_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b0;
        hy = bus.y;
        repeat (3) begin
          @(posedge clk);
          #1;
          if (!bus.in_ready) saw_stall = 1'b1;
          chk("bp_y_hold", 32'(bus.y), 32'(hy));
          chk("bp_valid_hold", 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_drop", 32'(saw_stall), 32'd1);
    chk("bp_count", 32'(count), 32'd4);

    // Full throughput.
    do_reset();
    waits_sum = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom_range(7, 0));
      send(ra, rb, rop, mk(ref_y(ra, rb, rop)), w);
      waits_sum += w;
    end
    chk("tp_no_input_stall", 32'(waits_sum), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("tp_count_no_bubble", 32'(count), 32'd20);

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send(8'h12, 8'h34, 3'd1, mk(ref_y(8'h12, 8'h34, 3'd1)), w);
    send(8'h56, 8'h78, 3'd5, mk(ref_y(8'h56, 8'h78, 3'd5)), w);
    chk("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
    do_reset();
    chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_count", 32'(count), 32'd0);
    chk("mid_y", 32'(bus.y), 32'd0);
    chk("mid_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end

    // Counter wrap on the 4-bit instance.
    nres = 0;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 40 && nres < 17; i++) begin
      @(negedge clk);
      hs = bus2.out_valid & bus2.out_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        nres++;
        if (nres == 15) chk("wrap_15", 32'(cnt2), 32'd15);
        if (nres == 16) chk("wrap_16", 32'(cnt2), 32'd0);
        if (nres == 17) chk("wrap_17", 32'(cnt2), 32'd1);
      end
    end
    bus2.in_valid = 1'b0;
    chk("wrap_results", 32'(nres), 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
